// File: rtl/dff_bank_pkg.sv
// Shared definitions for the D flip-flop register bank arbiter.
// Opcodes, arbiter FSM states and the round-robin pointer helper.
package dff_bank_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } st_e;

    function automatic int rr_next(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/dff_bank_reg.sv
// WIDTH-bit flop bank applying one masked op per enabled cycle.
// Ports: clk, clr (sync high), en, op, mask, data -> q, qn.
module dff_bank_reg
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = q;
        unique case (op)
            OP_LOAD:   nxt = (q & ~mask) | (data & mask);
            OP_SET:    nxt = q | mask;
            OP_CLEAR:  nxt = q & ~mask;
            OP_TOGGLE: nxt = q ^ mask;
        endcase
    end

    // qn is its own flop so both rails leave the bank registered
    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= '0;
            qn <= '1;
        end else if (en) begin
            q  <= nxt;
            qn <= ~nxt;
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter with lock bursts sharing one dff_bank_reg.
// Ports: clk, clr, req_* per requester -> req_ready, grant_vld, grant_id, q, qn.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_mask,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  grant_vld,
    output logic [IDW-1:0]        grant_id,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qn
);

    st_e            state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;

    logic           arb_hit;
    logic [IDW-1:0] arb_id;
    logic [IDW-1:0] idx;

    // first valid requester scanning ptr, ptr+1, ... modulo NREQ
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!arb_hit && req_valid[idx]) begin
                arb_hit = 1'b1;
                arb_id  = idx;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        if (!clr) begin
            case (state)
                ST_ARB: begin
                    grant_vld = arb_hit;
                    grant_id  = arb_id;
                end
                ST_LOCKED: begin
                    grant_vld = req_valid[owner];
                    grant_id  = req_valid[owner] ? owner : '0;
                end
            endcase
            if (grant_vld)
                req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (grant_vld) begin
                        ptr <= IDW'(rr_next(int'(grant_id), NREQ));
                        if (req_lock[grant_id]) begin
                            owner <= grant_id;
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    // owner dropping valid ends the burst without a transfer
                    if (!grant_vld) begin
                        state <= ST_ARB;
                    end else begin
                        ptr <= IDW'(rr_next(int'(owner), NREQ));
                        if (!req_lock[owner])
                            state <= ST_ARB;
                    end
                end
            endcase
        end
    end

    dff_bank_reg #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .clr  (clr),
        .en   (grant_vld),
        .op   (req_op[int'(grant_id)*2 +: 2]),
        .mask (req_mask[int'(grant_id)*WIDTH +: WIDTH]),
        .data (req_data[int'(grant_id)*WIDTH +: WIDTH]),
        .q    (q),
        .qn   (qn)
    );

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Testbench for dff_bank_arbiter: directed scenarios plus random traffic.
// Checks every cycle against a bit-level behavioural reference model.
module tb_dff_bank_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_lock = '0;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_mask = '0;
    logic [W*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           grant_vld;
    logic [1:0]     grant_id;
    logic [W-1:0]   q;
    logic [W-1:0]   qn;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] qm = '0;
    int           ptrm = 0;
    int           ownm = 0;
    bit           lockm = 1'b0;

    dff_bank_arbiter #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_op    (req_op),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .q         (q),
        .qn        (qn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit lk,
                           input logic [1:0] op, input logic [7:0] m,
                           input logic [7:0] d);
        req_valid[i]        = v;
        req_lock[i]         = lk;
        req_op[i*2 +: 2]    = op;
        req_mask[i*W +: W]  = m;
        req_data[i*W +: W]  = d;
    endtask

    function automatic int exp_grant();
        if (clr) return -1;
        if (lockm) return req_valid[ownm] ? ownm : -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(ptrm + k) % N]) return (ptrm + k) % N;
        return -1;
    endfunction

    function automatic logic [7:0] apply(input logic [7:0] cur,
                                         input logic [1:0] op,
                                         input logic [7:0] m,
                                         input logic [7:0] d);
        logic [7:0] r;
        r = cur;
        for (int b = 0; b < W; b++) begin
            if (m[b]) begin
                case (op)
                    2'd0: r[b] = d[b];
                    2'd1: r[b] = 1'b1;
                    2'd2: r[b] = 1'b0;
                    default: r[b] = ~cur[b];
                endcase
            end
        end
        return r;
    endfunction

    // one clock: check at negedge, update model at posedge, return #1 later
    task automatic cycle(output int gobs, output int gm);
        logic [7:0] qnm;
        int g;
        @(negedge clk);
        g   = exp_grant();
        qnm = ~qm;
        chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
        chk("gvld", grant_vld, (g >= 0) ? 1 : 0);
        chk("gid", grant_id, (g < 0) ? 0 : g);
        chk("q", q, qm);
        chk("qn", qn, qnm);
        gobs = grant_vld ? int'(grant_id) : -1;
        gm   = g;
        @(posedge clk);
        if (clr) begin
            qm = '0; ptrm = 0; ownm = 0; lockm = 1'b0;
        end else if (g >= 0) begin
            qm    = apply(qm, req_op[g*2 +: 2], req_mask[g*W +: W],
                          req_data[g*W +: W]);
            ptrm  = (g + 1) % N;
            lockm = req_lock[g];
            ownm  = g;
        end else begin
            lockm = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        int a, b;
        clr = 1'b1;
        cycle(a, b);
        clr = 1'b0;
    endtask

    initial begin
        int go, gm;

        // reset with every requester valid
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 2'd0, 8'hFF, 8'h77);
        cycle(go, gm);
        cycle(go, gm);
        chk("rst_rdy", req_ready, 0);
        chk("rst_q", q, 8'h00);
        chk("rst_qn", qn, 8'hFF);
        clr = 1'b0;
        cycle(go, gm);
        chk("rst_first", go, 0);

        // round-robin fairness with full loads
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 1, 0, 2'd0, 8'hFF, 8'(8'h11 * (i + 1)));
        for (int n = 0; n < 5; n++) begin
            cycle(go, gm);
            chk("rr_gid", go, n % N);
            chk("rr_q", q, 8'h11 * ((n % N) + 1));
        end

        // masked ops from F0 on requester 0 only
        do_reset();
        req_valid = '0;
        set_req(0, 1, 0, 2'd0, 8'hFF, 8'hF0); cycle(go, gm);
        chk("op_load", q, 8'hF0);
        set_req(0, 1, 0, 2'd1, 8'h0F, 8'h00); cycle(go, gm);
        chk("op_set", q, 8'hFF);
        set_req(0, 1, 0, 2'd2, 8'h3C, 8'h00); cycle(go, gm);
        chk("op_clear", q, 8'hC3);
        set_req(0, 1, 0, 2'd3, 8'hFF, 8'h00); cycle(go, gm);
        chk("op_toggle", q, 8'h3C);
        set_req(0, 1, 0, 2'd0, 8'h0F, 8'hAA); cycle(go, gm);
        chk("op_loadm", q, 8'h3A);

        // lock burst by requester 2 with requester 1 waiting
        req_valid = '0;
        do_reset();
        set_req(1, 1, 0, 2'd1, 8'h01, 8'h00); cycle(go, gm);
        chk("lk_pre", go, 1);
        set_req(2, 1, 1, 2'd1, 8'h80, 8'h00); cycle(go, gm);
        chk("lk_b0", go, 2);
        set_req(2, 1, 1, 2'd3, 8'hFF, 8'h00); cycle(go, gm);
        chk("lk_b1", go, 2);
        set_req(2, 1, 0, 2'd2, 8'h0F, 8'h00); cycle(go, gm);
        chk("lk_b2", go, 2);
        set_req(0, 1, 0, 2'd0, 8'hFF, 8'h01);
        set_req(2, 0, 0, 2'd0, 8'h00, 8'h00);
        set_req(3, 1, 0, 2'd0, 8'hFF, 8'h03);
        cycle(go, gm); chk("lk_after3", go, 3);
        cycle(go, gm); chk("lk_after0", go, 0);
        cycle(go, gm); chk("lk_after1", go, 1);

        // lock abandon by requester 3
        req_valid = '0;
        do_reset();
        set_req(3, 1, 1, 2'd1, 8'hF0, 8'h00); cycle(go, gm);
        chk("ab_lock", go, 3);
        set_req(3, 0, 0, 2'd0, 8'h00, 8'h00);
        set_req(0, 1, 0, 2'd1, 8'h01, 8'h00);
        set_req(1, 1, 0, 2'd1, 8'h02, 8'h00);
        cycle(go, gm); chk("ab_drop", go, -1);
        cycle(go, gm); chk("ab_next", go, 0);

        // clr in the middle of a burst
        req_valid = '0;
        do_reset();
        set_req(0, 1, 1, 2'd0, 8'hFF, 8'h5A); cycle(go, gm);
        chk("cm_load", q, 8'h5A);
        set_req(1, 1, 0, 2'd1, 8'h10, 8'h00);
        clr = 1'b1;
        cycle(go, gm);
        chk("cm_q", q, 8'h00);
        clr = 1'b0;
        set_req(0, 1, 0, 2'd1, 8'h01, 8'h00);
        cycle(go, gm); chk("cm_first", go, 0);
        cycle(go, gm); chk("cm_second", go, 1);

        // random traffic; commands held until transferred
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clr = ($urandom_range(0, 99) < 3);
            cycle(go, gm);
            for (int i = 0; i < N; i++) begin
                if (i == gm || !req_valid[i]) begin
                    if ($urandom_range(0, 99) < 55)
                        set_req(i, 1, ($urandom_range(0, 99) < 30),
                                2'($urandom), 8'($urandom), 8'($urandom));
                    else
                        req_valid[i] = 1'b0;
                end
            end
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit register bank built from D flip-flops.
- Shares the bank between NREQ requesters and serialises their write commands, one per cycle.
- Supported commands: load, preset, clear and toggle, each applied under a per-bit mask.
- Drives registered true and complement outputs (q/qn) to downstream logic; supports lock-based bursts for one owner.

Parameters:
- WIDTH, 8, bank width in bits.
- NREQ, 4, number of requesters; must be at least 2.
- IDW, 2, grant index width; equals clog2(NREQ).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- clr  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester command valid.
- req_lock  input  NREQ  keep grant after this transfer (burst).
- req_op  input  2*NREQ  per-requester opcode: 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
- req_mask  input  WIDTH*NREQ  per-requester bit mask; 1 = bit affected.
- req_data  input  WIDTH*NREQ  per-requester load data; used by LOAD only.
- req_ready  output  NREQ  one-hot grant, combinational from state and req_valid.
- grant_vld  output  1  a transfer occurs this cycle.
- grant_id  output  IDW  index of the granted requester; 0 when grant_vld=0.
- q  output  WIDTH  bank contents (registered).
- qn  output  WIDTH  bitwise complement of q.

Behaviour:
- Reset (clr=1 at posedge):
  - q=0, qn=all ones.
  - Priority pointer ptr=0; state=ARB; owner=0.
  - While clr=1, req_ready=0 and grant_vld=0; no command is applied.
  - clr mid-burst abandons the lock immediately.
- Transfer rule: requester i transfers when req_valid[i] and req_ready[i] are both 1. At most one transfer per cycle.
- Bank update occurs on the same posedge as the transfer; q is visible the next cycle (latency 1).
  - LOAD: q <= (q & ~m) | (d & m)
  - SET: q <= q | m
  - CLEAR: q <= q & ~m
  - TOGGLE: q <= q ^ m
  - mask=0: a legal transfer with no bit change; ptr and lock still update.
- No transfer: q holds.
- State ARB:
  - Grant the first valid requester scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - On a transfer by i with req_lock[i]=0: ptr <= (i+1) mod NREQ; stay in ARB.
  - On a transfer by i with req_lock[i]=1: owner <= i; go to LOCKED; ptr <= (i+1) mod NREQ.
- State LOCKED:
  - Only the owner may be granted; req_ready is 0 for all others, even if valid.
  - Owner transfers with lock=1: stay in LOCKED.
  - Owner transfers with lock=0: go to ARB.
  - Owner drops req_valid: go to ARB at that posedge, with no transfer that cycle and ptr unchanged (already advanced).
- Wrap-around: ptr = NREQ-1 advances to 0.
- Requester handshake rule: once req_valid is asserted, op/mask/data/lock are held stable until transfer. The arbiter does not check this.
- Idle: no valid requester gives grant_vld=0 and grant_id=0; ptr and state are unchanged.

Decomposition:
- Shared package dff_bank_pkg:
  - Opcode localparams OP_LOAD=2'b00, OP_SET=2'b01, OP_CLEAR=2'b10, OP_TOGGLE=2'b11.
  - State encodings ST_ARB, ST_LOCKED.
- One natural sub-module, dff_bank_reg:
  - WIDTH-bit register with the op/mask/data update function and clr.
  - Outputs q and qn.
- The arbiter top (round-robin search, lock FSM) instantiates dff_bank_reg once.

Test Plan:
1. Reset: drive clr=1 for 2 cycles with all req_valid=1 -> req_ready=0000, q=8'h00, qn=8'hFF; after release, first grant goes to requester 0.
2. Round-robin fairness: all four valid, LOAD with mask=FF, data=8'h11/22/33/44, lock=0 -> grants in order 0,1,2,3,0; q sequence 11,22,33,44,11.
3. Masked ops from q=8'hF0:
   - SET mask 0F -> FF
   - CLEAR mask 3C -> C3
   - TOGGLE mask FF -> 3C
   - LOAD data AA mask 0F -> 3A
4. Lock burst: requester 2 issues 3 transfers with lock=1,1,0 while requester 1 is valid -> requester 1 is not granted during the burst; after the burst, ptr=3, so the next grant order is 3 (if valid), then 0, then 1.
5. Lock abandon: requester 3 locks, then drops valid -> FSM returns to ARB with no transfer that cycle; next grant goes to 0 (ptr wrapped).
6. clr mid-burst: assert clr while LOCKED with q=8'h5A -> q=00, state ARB, ptr=0; requester 0 is granted first after release.
